// File: rtl/cb_synthesis.sv
// Huffman codebook synthesis: depth-first walk of an indexed node array that
// emits each leaf's character and code, handshaking with the header writer.
module cb_synthesis (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   max_index,
  input  logic [70:0]  h_element,
  input  logic         write_finish,
  output logic [6:0]   curr_index,
  output logic [127:0] curr_path,
  output logic [127:0] char_path,
  output logic [7:0]   char_index,
  output logic         char_found,
  output logic [8:0]   least1,
  output logic [8:0]   least2,
  output logic [6:0]   track_length,
  output logic [6:0]   pos,
  output logic         wait_cycle,
  output logic [2:0]   curr_state,
  output logic [3:0]   finished
);

  typedef enum logic [2:0] {
    S_LEFT      = 3'd0,
    S_RIGHT     = 3'd1,
    S_TRACK     = 3'd2,
    S_BACKTRACK = 3'd3,
    S_FINISH    = 3'd4,
    S_INIT      = 3'd5,
    S_SEND      = 3'd6
  } state_e;

  state_e         state_q;
  state_e         ret_q;
  logic [6:0]     curr_index_q;
  logic [127:0]   curr_path_q;
  logic [127:0]   char_path_q;
  logic [7:0]     char_index_q;
  logic           char_found_q;
  logic [8:0]     least1_q;
  logic [8:0]     least2_q;
  logic [6:0]     track_length_q;
  logic [6:0]     pos_q;
  logic           wait_q;
  logic [3:0]     finished_q;

  // Child field decode: bit8 clear is a leaf, bit8 and bit7 set is null.
  logic [8:0] left_w;
  logic [8:0] right_w;
  logic       left_leaf_w;
  logic       left_null_w;
  logic       right_leaf_w;
  logic       right_null_w;
  logic       unused_w;

  assign left_w       = h_element[63:55];
  assign right_w      = h_element[54:46];
  assign left_leaf_w  = ~left_w[8];
  assign left_null_w  = left_w[8] & left_w[7];
  assign right_leaf_w = ~right_w[8];
  assign right_null_w = right_w[8] & right_w[7];
  assign unused_w     = ^{h_element[70:64], h_element[45:0]};

  // NOTE: every register here updates with <= so all next-state values are
  // computed from the same pre-edge snapshot regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_INIT;
      ret_q          <= S_RIGHT;
      curr_index_q   <= 7'd0;
      curr_path_q    <= 128'd1;
      char_path_q    <= 128'd0;
      char_index_q   <= 8'd0;
      char_found_q   <= 1'b0;
      least1_q       <= 9'd0;
      least2_q       <= 9'd0;
      track_length_q <= 7'd0;
      pos_q          <= 7'd0;
      wait_q         <= 1'b0;
      finished_q     <= 4'b0000;
    end else begin
      case (state_q)
        S_INIT: begin
          curr_index_q   <= max_index;
          curr_path_q    <= 128'd1;
          track_length_q <= 7'd0;
          wait_q         <= 1'b1;
          state_q        <= S_LEFT;
        end

        S_LEFT: begin
          if (wait_q) begin
            wait_q <= 1'b0;
          end else begin
            least1_q <= left_w;
            least2_q <= right_w;
            if (left_null_w) begin
              state_q <= S_RIGHT;
            end else if (left_leaf_w) begin
              char_index_q <= left_w[7:0];
              char_path_q  <= {curr_path_q[126:0], 1'b0};
              char_found_q <= 1'b1;
              ret_q        <= S_RIGHT;
              state_q      <= S_SEND;
            end else begin
              curr_path_q    <= {curr_path_q[126:0], 1'b0};
              track_length_q <= track_length_q + 7'd1;
              curr_index_q   <= left_w[6:0];
              wait_q         <= 1'b1;
            end
          end
        end

        S_RIGHT: begin
          if (wait_q) begin
            wait_q <= 1'b0;
          end else if (right_null_w) begin
            state_q <= S_BACKTRACK;
          end else if (right_leaf_w) begin
            char_index_q <= right_w[7:0];
            char_path_q  <= {curr_path_q[126:0], 1'b1};
            char_found_q <= 1'b1;
            ret_q        <= S_BACKTRACK;
            state_q      <= S_SEND;
          end else begin
            curr_path_q    <= {curr_path_q[126:0], 1'b1};
            track_length_q <= track_length_q + 7'd1;
            curr_index_q   <= right_w[6:0];
            wait_q         <= 1'b1;
            state_q        <= S_LEFT;
          end
        end

        S_SEND: begin
          if (write_finish) begin
            char_found_q <= 1'b0;
            state_q      <= ret_q;
          end
        end

        // One path bit per cycle; a trailing 0 marks a parent whose right
        // subtree is still unvisited, so re-walk from the root to reach it.
        S_BACKTRACK: begin
          if (curr_path_q == 128'd1) begin
            finished_q <= 4'b0101;
            state_q    <= S_FINISH;
          end else begin
            curr_path_q    <= curr_path_q >> 1;
            track_length_q <= track_length_q - 7'd1;
            if (!curr_path_q[0]) begin
              pos_q        <= track_length_q - 7'd1;
              curr_index_q <= max_index;
              wait_q       <= 1'b1;
              state_q      <= S_TRACK;
            end
          end
        end

        S_TRACK: begin
          if (wait_q) begin
            wait_q <= 1'b0;
          end else if (pos_q == 7'd0) begin
            state_q <= S_RIGHT;
          end else begin
            curr_index_q <= curr_path_q[pos_q - 7'd1] ? right_w[6:0] : left_w[6:0];
            pos_q        <= pos_q - 7'd1;
            wait_q       <= 1'b1;
          end
        end

        S_FINISH: begin
          finished_q <= 4'b0101;
        end

        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign curr_index   = curr_index_q;
  assign curr_path    = curr_path_q;
  assign char_path    = char_path_q;
  assign char_index   = char_index_q;
  assign char_found   = char_found_q;
  assign least1       = least1_q;
  assign least2       = least2_q;
  assign track_length = track_length_q;
  assign pos          = pos_q;
  assign wait_cycle   = wait_q;
  assign curr_state   = state_q;
  assign finished     = finished_q;

endmodule

// File: tb/tb_cb_synthesis.sv
// Directed bench for cb_synthesis: a DFS reference model fills a scoreboard
// of (char, code) pairs that are compared as the DUT presents each leaf.
module tb_cb_synthesis;

  logic         clk;
  logic         rst;
  logic [6:0]   max_index;
  logic [70:0]  h_element;
  logic         write_finish;
  logic [6:0]   curr_index;
  logic [127:0] curr_path;
  logic [127:0] char_path;
  logic [7:0]   char_index;
  logic         char_found;
  logic [8:0]   least1;
  logic [8:0]   least2;
  logic [6:0]   track_length;
  logic [6:0]   pos;
  logic         wait_cycle;
  logic [2:0]   curr_state;
  logic [3:0]   finished;

  typedef struct {
    logic [7:0]   ch;
    logic [127:0] path;
  } leaf_t;

  localparam logic [8:0] NULLC  = 9'h180;
  localparam int         BUDGET = 20000;

  logic [70:0] mem [0:127];
  leaf_t       exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  cb_synthesis dut (
    .clk          (clk),
    .rst          (rst),
    .max_index    (max_index),
    .h_element    (h_element),
    .write_finish (write_finish),
    .curr_index   (curr_index),
    .curr_path    (curr_path),
    .char_path    (char_path),
    .char_index   (char_index),
    .char_found   (char_found),
    .least1       (least1),
    .least2       (least2),
    .track_length (track_length),
    .pos          (pos),
    .wait_cycle   (wait_cycle),
    .curr_state   (curr_state),
    .finished     (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tree memory with one cycle of read latency.
  always @(posedge clk) h_element <= mem[curr_index];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] nd(input int i);
    logic [6:0] idx;
    idx = i[6:0];
    return {2'b10, idx};
  endfunction

  function automatic logic [8:0] lf(input int c);
    logic [7:0] ch;
    ch = c[7:0];
    return {1'b0, ch};
  endfunction

  function automatic logic [70:0] node(input logic [8:0] l, input logic [8:0] r);
    return {7'd0, l, r, 46'd0};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = node(NULLC, NULLC);
  endtask

  // Reference DFS with an explicit stack: left subtree fully before right.
  task automatic build_expected();
    logic [8:0]   st_c [$];
    logic [127:0] st_p [$];
    logic [8:0]   c;
    logic [127:0] p;
    logic [70:0]  w;
    leaf_t        e;
    exp_q.delete();
    st_c.push_back(nd(int'(max_index)));
    st_p.push_back(128'd1);
    while (st_c.size() > 0) begin
      c = st_c.pop_back();
      p = st_p.pop_back();
      if (c[8] && c[7]) continue;
      if (!c[8]) begin
        e.ch   = c[7:0];
        e.path = p;
        exp_q.push_back(e);
      end else begin
        w = mem[c[6:0]];
        st_c.push_back(w[54:46]);
        st_p.push_back({p[126:0], 1'b1});
        st_c.push_back(w[63:55]);
        st_p.push_back({p[126:0], 1'b0});
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    write_finish = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_state",     curr_state,   3'd5);
    check("rst_index",     curr_index,   7'd0);
    check("rst_path",      curr_path,    128'd1);
    check("rst_char_path", char_path,    128'd0);
    check("rst_char_idx",  char_index,   8'd0);
    check("rst_found",     char_found,   1'b0);
    check("rst_least1",    least1,       9'd0);
    check("rst_least2",    least2,       9'd0);
    check("rst_tlen",      track_length, 7'd0);
    check("rst_pos",       pos,          7'd0);
    check("rst_wait",      wait_cycle,   1'b0);
    check("rst_finished",  finished,     4'd0);
    rst = 1'b0;
    @(negedge clk);
    check("init_state", curr_state, 3'd0);
    check("init_index", curr_index, max_index);
    check("init_wait",  wait_cycle, 1'b1);
  endtask

  task automatic compare_leaf(input string tag, output leaf_t e);
    check({tag, "_leaf_expected"}, exp_q.size() != 0, 1'b1);
    e.ch   = 8'hxx;
    e.path = 'x;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_char"}, char_index, e.ch);
      check({tag, "_code"}, char_path,  e.path);
    end
  endtask

  task automatic run_walk(input string tag, input int stall);
    int    cyc;
    leaf_t e;
    cyc          = 0;
    write_finish = (stall == 0);
    while (finished !== 4'b0101 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (char_found === 1'b1) begin
        compare_leaf(tag, e);
        if (stall > 0) begin
          repeat (stall) begin
            @(negedge clk);
            cyc++;
            check({tag, "_stall_found"}, char_found, 1'b1);
            check({tag, "_stall_code"},  char_path,  e.path);
          end
          write_finish = 1'b1;
          @(negedge clk);
          cyc++;
          write_finish = 1'b0;
          check({tag, "_release"}, char_found, 1'b0);
        end
      end
    end
    check({tag, "_finished"},    finished,     4'b0101);
    check({tag, "_leaves_left"}, exp_q.size(), 0);
    check({tag, "_final_state"}, curr_state,   3'd4);
    repeat (4) @(negedge clk);
    check({tag, "_sticky"},      finished,     4'b0101);
    check({tag, "_found_low"},   char_found,   1'b0);
  endtask

  task automatic load_tree9();
    clear_mem();
    mem[0] = node(lf("C"), lf("B"));
    mem[1] = node(lf("D"), lf("E"));
    mem[2] = node(lf("H"), lf("I"));
    mem[3] = node(nd(0),   lf("A"));
    mem[4] = node(lf("F"), nd(1));
    mem[5] = node(lf("G"), nd(2));
    mem[6] = node(nd(3),   nd(4));
    mem[7] = node(lf("J"), nd(5));
    mem[8] = node(nd(6),   nd(7));
    max_index = 7'd8;
  endtask

  initial begin
    int    cyc;
    leaf_t e;
    rst          = 1'b1;
    write_finish = 1'b0;
    max_index    = 7'd0;
    clear_mem();

    // Single-leaf tree: one leaf 'C' with code 0b10.
    mem[0] = node(lf("C"), NULLC);
    max_index = 7'd0;
    build_expected();
    check("single_model_code", exp_q[0].path, 128'd2);
    do_reset();
    run_walk("single", 0);

    // Nine-node tree with a five-cycle header stall on every leaf.
    load_tree9();
    build_expected();
    check("tree9_model_count", exp_q.size(), 10);
    check("tree9_model_first", exp_q[0].path, 128'h10);
    check("tree9_model_j",     exp_q[6].path, 128'h6);
    do_reset();
    run_walk("tree9", 5);

    // Right-leaning chain: deepest code is 31 bits.
    clear_mem();
    mem[0] = node(lf(48), lf(49));
    for (int k = 1; k <= 30; k++) mem[k] = node(lf(65 + k - 1), nd(k - 1));
    max_index = 7'd30;
    build_expected();
    do_reset();
    run_walk("chain", 0);

    // Near-perfect tree of 47 internal nodes (heap layout, node = 46 - heap).
    clear_mem();
    for (int h = 0; h <= 46; h++) begin
      logic [8:0] l;
      logic [8:0] r;
      l = (2 * h + 1 <= 46) ? nd(46 - (2 * h + 1)) : lf(2 * h + 1);
      r = (2 * h + 2 <= 46) ? nd(46 - (2 * h + 2)) : lf(2 * h + 2);
      mem[46 - h] = node(l, r);
    end
    max_index = 7'd46;
    build_expected();
    check("tree47_model_count", exp_q.size(), 48);
    do_reset();
    run_walk("tree47", 0);

    // Mid-walk reset once the walk reaches node max_index/2.
    load_tree9();
    build_expected();
    do_reset();
    write_finish = 1'b1;
    cyc = 0;
    while (curr_index !== 7'd4 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (char_found === 1'b1) compare_leaf("pre_reset", e);
    end
    check("midreset_reached", curr_index, 7'd4);
    build_expected();
    do_reset();
    run_walk("post_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
